alu_op_sequencer: RTL and testbench

- Multi-cycle controller that accepts 16-bit instruction words over a valid/ready handshake, reads operands from a 16x16 register file, drives the combinational 16-bit ALU (ADD/SUB/AND/SLL/ADDI/LW address), issues load requests to data memory, and writes results back.
- Sits between the instruction fetch stage and the ALU/regfile/memory datapath. It owns all sequencing, including load-memory timeout detection.

---
 rtl/alu_op_sequencer.sv | 173 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer: accepts one instruction at a time, drives an external ALU,
// regfile and load port, then writes the result back with a single-cycle strobe.
module alu_op_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TW      = 5
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,

    output logic [3:0]  rf_ra0,
    output logic [3:0]  rf_ra1,
    input  logic [15:0] rf_rd0,
    input  logic [15:0] rf_rd1,

    output logic [2:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_y,

    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,

    output logic        wb_en,
    output logic [3:0]  wb_addr,
    output logic [15:0] wb_data,

    output logic        busy,
    output logic        err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StMem  = 2'd2;
    localparam logic [1:0] StWb   = 2'd3;

    localparam logic [3:0] OpLw   = 4'd5;
    localparam logic [2:0] AluAdd = 3'd0;

    // Value of the counter during the last permitted MEM cycle.
    localparam logic [TW-1:0] CntLast = TW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [15:0]   instr_q, instr_d;
    logic [15:0]   res_q, res_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] imm_sext;
    logic        is_rtype;
    logic        is_load;
    logic        in_legal;

    assign op       = instr_q[15:12];
    assign rd       = instr_q[11:8];
    assign rs       = instr_q[7:4];
    assign rt       = instr_q[3:0];
    assign imm_sext = {{8{instr_q[7]}}, instr_q[7:0]};
    assign is_rtype = (op[3:2] == 2'b00);
    assign is_load  = (op == OpLw);
    assign in_legal = (instr[15:12] <= OpLw);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    if (in_legal) begin
                        instr_d = instr;
                        state_d = StExec;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StExec: begin
                res_d   = alu_y;
                cnt_d   = '0;
                state_d = is_load ? StMem : StWb;
            end
            StMem: begin
                cnt_d = cnt_q + 1'b1;
                // An ack in the final permitted cycle still completes the load.
                if (mem_ack) begin
                    res_d   = mem_rdata;
                    state_d = StWb;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        instr_ready = (state_q == StIdle);
        busy        = (state_q != StIdle);
        err         = err_q;
        rf_ra0      = '0;
        rf_ra1      = '0;
        alu_op      = '0;
        alu_a       = '0;
        alu_b       = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        case (state_q)
            StExec: begin
                if (is_rtype) begin
                    rf_ra0 = rs;
                    rf_ra1 = rt;
                    alu_a  = rf_rd0;
                    alu_b  = rf_rd1;
                    alu_op = op[2:0];
                end else begin
                    rf_ra0 = rd;
                    alu_a  = rf_rd0;
                    alu_b  = imm_sext;
                    alu_op = AluAdd;
                end
            end
            StMem: begin
                mem_req  = 1'b1;
                mem_addr = res_q;
            end
            StWb: begin
                wb_en   = 1'b1;
                wb_addr = rd;
                wb_data = res_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            instr_q <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural regfile and ALU around it.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  rf_ra0, rf_ra1;
    logic [15:0] rf_rd0, rf_rd1;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_y;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf [16];
    logic        pl_en;
    logic [3:0]  pl_addr;
    logic [15:0] pl_data;
    int          wb_count = 0;
    int          wb_saved;

    alu_op_sequencer #(.TIMEOUT(16), .TW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_ra0      (rf_ra0),
        .rf_ra1      (rf_ra1),
        .rf_rd0      (rf_rd0),
        .rf_rd1      (rf_rd1),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_y       (alu_y),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    assign rf_rd0 = rf[rf_ra0];
    assign rf_rd1 = rf[rf_ra1];

    always_comb begin
        alu_y = '0;
        case (alu_op)
            3'd0: alu_y = alu_a + alu_b;
            3'd1: alu_y = alu_a - alu_b;
            3'd2: alu_y = alu_a & alu_b;
            3'd3: alu_y = alu_a << alu_b[3:0];
            default: alu_y = '0;
        endcase
    end

    always @(posedge clk) begin
        if (wb_en) begin
            rf[wb_addr] <= wb_data;
            wb_count    <= wb_count + 1;
        end
        if (pl_en) rf[pl_addr] <= pl_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Presents an instruction for exactly one edge; returns just after that edge.
    task automatic issue(input logic [15:0] w);
        instr_valid = 1'b1;
        instr       = w;
        step();
        instr_valid = 1'b0;
        instr       = '0;
    endtask

    task automatic alu_instr(input string tag, input logic [15:0] w,
                             input logic [3:0] exp_rd, input logic [15:0] exp_data);
        issue(w);
        chk({tag, "_exec_busy"}, {15'd0, busy}, 16'd1);
        step();
        chk({tag, "_wb_en"}, {15'd0, wb_en}, 16'd1);
        chk({tag, "_wb_addr"}, {12'd0, wb_addr}, {12'd0, exp_rd});
        chk({tag, "_wb_data"}, wb_data, exp_data);
        step();
        chk({tag, "_idle_ready"}, {15'd0, instr_ready}, 16'd1);
    endtask

    initial begin
        clk         = 1'b0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        pl_en       = 1'b0;
        pl_addr     = '0;
        pl_data     = '0;
        for (int i = 0; i < 16; i++) rf[i] = '0;

        do_reset();
        chk("rst_ready", {15'd0, instr_ready}, 16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
        chk("rst_wb_en", {15'd0, wb_en}, 16'd0);
        chk("rst_alu_a", alu_a, 16'h0000);

        // ADD r3 = r1 + r2
        set_reg(4'd1, 16'h7FFF);
        set_reg(4'd2, 16'h0001);
        issue(16'h0312);
        chk("add_busy_exec", {15'd0, busy}, 16'd1);
        chk("add_ready_exec", {15'd0, instr_ready}, 16'd0);
        chk("add_alu_a", alu_a, 16'h7FFF);
        chk("add_alu_b", alu_b, 16'h0001);
        chk("add_alu_op", {13'd0, alu_op}, 16'd0);
        step();
        chk("add_wb_en", {15'd0, wb_en}, 16'd1);
        chk("add_wb_addr", {12'd0, wb_addr}, 16'd3);
        chk("add_wb_data", wb_data, 16'h8000);
        chk("add_busy_wb", {15'd0, busy}, 16'd1);
        step();
        chk("add_busy_done", {15'd0, busy}, 16'd0);
        chk("add_wb_off", {15'd0, wb_en}, 16'd0);

        // Back-to-back dependent read: r9 = r3 + r2
        alu_instr("raw_add", 16'h0932, 4'd9, 16'h8001);

        // SUB wrap and SLL
        set_reg(4'd1, 16'h0000);
        alu_instr("sub", 16'h1612, 4'd6, 16'hFFFF);
        set_reg(4'd1, 16'h0003);
        set_reg(4'd2, 16'h0004);
        alu_instr("sll", 16'h3712, 4'd7, 16'h0030);

        // AND
        set_reg(4'd1, 16'hF0F0);
        set_reg(4'd2, 16'h3C3C);
        alu_instr("and", 16'h2A12, 4'd10, 16'h3030);

        // ADDI r4 = 0x0010 + sext(0xF0)
        set_reg(4'd4, 16'h0010);
        issue(16'h44F0);
        chk("addi_alu_b", alu_b, 16'hFFF0);
        chk("addi_alu_op", {13'd0, alu_op}, 16'd0);
        step();
        chk("addi_wb_en", {15'd0, wb_en}, 16'd1);
        chk("addi_wb_data", wb_data, 16'h0000);
        step();

        // LW r5 = mem[0x0100 + 4], ack after three low cycles
        set_reg(4'd5, 16'h0100);
        issue(16'h5504);
        step();
        chk("lw_mem_req", {15'd0, mem_req}, 16'd1);
        chk("lw_mem_addr", mem_addr, 16'h0104);
        chk("lw_no_wb_mem", {15'd0, wb_en}, 16'd0);
        step();
        step();
        step();
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        chk("lw_wb_en", {15'd0, wb_en}, 16'd1);
        chk("lw_wb_addr", {12'd0, wb_addr}, 16'd5);
        chk("lw_wb_data", wb_data, 16'hBEEF);
        chk("lw_mem_req_off", {15'd0, mem_req}, 16'd0);
        step();
        chk("lw_err", {15'd0, err}, 16'd0);

        // LW timeout: no ack for 16 MEM cycles
        set_reg(4'd8, 16'h0000);
        wb_saved = wb_count;
        issue(16'h5820);
        step();
        for (int i = 0; i < 16; i++) begin
            chk("to_mem_req_held", {15'd0, mem_req}, 16'd1);
            step();
        end
        chk("to_mem_req_drop", {15'd0, mem_req}, 16'd0);
        chk("to_err", {15'd0, err}, 16'd1);
        chk("to_ready", {15'd0, instr_ready}, 16'd1);
        step();
        chk("to_no_wb", 16'(wb_count - wb_saved), 16'd0);

        // LW with ack exactly on the 16th MEM cycle
        do_reset();
        chk("rst_clears_err", {15'd0, err}, 16'd0);
        issue(16'h5820);
        step();
        for (int i = 0; i < 15; i++) step();
        chk("edge_mem_req", {15'd0, mem_req}, 16'd1);
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        chk("edge_wb_en", {15'd0, wb_en}, 16'd1);
        chk("edge_wb_data", wb_data, 16'h1234);
        chk("edge_err", {15'd0, err}, 16'd0);
        step();

        // Illegal opcode
        wb_saved = wb_count;
        issue(16'h9123);
        chk("ill_err", {15'd0, err}, 16'd1);
        chk("ill_ready", {15'd0, instr_ready}, 16'd1);
        chk("ill_busy", {15'd0, busy}, 16'd0);
        step();
        step();
        chk("ill_no_wb", 16'(wb_count - wb_saved), 16'd0);

        // Reset during MEM, then a stray ack
        do_reset();
        wb_saved = wb_count;
        issue(16'h5820);
        step();
        step();
        chk("rm_mem_req", {15'd0, mem_req}, 16'd1);
        rst_n = 1'b0;
        step();
        chk("rm_req_drop", {15'd0, mem_req}, 16'd0);
        rst_n = 1'b1;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        step();
        step();
        chk("rm_no_wb", 16'(wb_count - wb_saved), 16'd0);
        chk("rm_err", {15'd0, err}, 16'd0);
        chk("rm_ready", {15'd0, instr_ready}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
